led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
Parametrised successor to the team's single-dot LED ripple. It drives an N-bit LED bank with one of four patterns: rotate left, rotate right, bounce (ping-pong), or fill/drain bar. Steps are paced by a programmable prescaler. The block sits between board switches/buttons and the LED pins. It adds reset, run/pause, single-step, a runtime period and a step strobe.

Parameters:
N_LEDS, 8, width of LED bank (>=2)
CNT_W, 32, prescaler counter width
DEFAULT_PERIOD, 50000000, period substituted when period input is 0

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = free-running stepping; 0 = paused
step_req  input  1  one-cycle pulse; forces one step when paused (ignored while run=1)
mode  input  2  0 rotL, 1 rotR, 2 bounce, 3 fill/drain
period  input  CNT_W  clocks per step; 0 selects DEFAULT_PERIOD
leds  output  N_LEDS  LED drive, bit 0 = LED0
tick  output  1  one-cycle pulse in the cycle leds updates
dir  output  1  current bounce/fill direction (0 = up/fill, 1 = down/drain)

Behaviour:
- Clocking/reset: one clock is used. Reset is asynchronous and active-low. While rst_n=0: leds=1 (only LED0 lit), counter=0, tick=0, dir=0, cur_mode=0.
- Effective period: P = (period==0) ? DEFAULT_PERIOD : period.
- Prescaler, run=1: counter increments each clock. When counter >= P-1, a step fires and counter clears to 0. Using >= means lowering period mid-count fires on the next clock, with no wrap through 2^CNT_W. With P=1, a step fires every clock.
- Pause, run=0: counter holds its value. A step fires in the cycle after step_req=1, and counter is unchanged. step_req while run=1 is ignored.
- Step timing: leds, dir and cur_mode update on the step clock edge. tick=1 for exactly that one cycle.
- Mode latch: mode is sampled only on a step. If mode != cur_mode, the step is a reload: leds=1, dir=0, cur_mode=mode. No pattern move occurs on a reload step.
- Mode 0 rotL: leds = {leds[N-2:0], leds[N-1]}.
- Mode 1 rotR: leds = {leds[0], leds[N-1:1]}.
- Mode 2 bounce: exactly one bit is set.
  - dir=0: shift left. When the new position is N-1, set dir=1.
  - dir=1: shift right. When the new position is 0, set dir=0.
  - Sequence for N=8: 0,1,...,7,6,...,1,0,1,... Ends are not repeated.
- Mode 3 fill/drain:
  - dir=0: leds = (leds<<1)|1. When the result is all-ones, set dir=1.
  - dir=1: leds = leds<<1 (zeros enter at LED0). When the result is 0, set dir=0.
  - Full cycle length is 2N steps; the all-zero state is shown for one step.
  - Cycle from reset value 0x01: 0x03, ..., 0xFF, 0xFE, ..., 0x80, 0x00, 0x01, ...
- Illegal states: in modes 0-2, if leds==0 at a step (e.g. after an SEU), reload leds=1, dir=0.
- Simultaneous events: step_req and a run 1->0 edge in the same cycle give at most one step. rst_n assertion overrides everything, including a step in flight.
- Outputs are registered; there is no combinational path from inputs to leds or tick.

Decomposition:
- Shared package led_pkg:
  - Mode encodings: MODE_ROTL=2'd0, MODE_ROTR=2'd1, MODE_BOUNCE=2'd2, MODE_FILL=2'd3.
  - DEFAULT_PERIOD constant.
- Sub-module step_prescaler (clk, rst_n, run, step_req, period -> step): holds the counter, the >= compare, and the period-0 substitution. The pattern datapath/FSM stays in the top module.

Test Plan (N_LEDS=8, CNT_W=8 where noted, DEFAULT_PERIOD=5):
- Reset then run=1, mode=0, period=4 -> first tick on 4th clock after reset release. leds goes 0x01→0x02→...→0x80→0x01. tick is high every 4 clocks, width 1.
- mode=2, period=1 -> after reload step (leds=0x01), leds goes 02,04,...,80 (dir→1), 40,...,01 (dir→0), 02. 0x80 and 0x01 each appear once per pass.
- mode=3, period=1 -> after reload: 03,07,...,FF(dir=1),FE,FC,...,80,00(dir=0),01,03. Period is 16 steps.
- period=0 -> steps every 5 clocks. period changed from 200 to 3 while counter=50 (CNT_W=8) -> tick on next clock, then every 3.
- run=0: leds frozen for 100 clocks. Three step_req pulses -> exactly three ticks and three pattern moves. step_req with run=1 -> no extra tick.
- Assert rst_n low mid-pattern (leds=0x20, dir=1, asynchronous to clk) -> leds=0x01, dir=0, tick=0 immediately, without waiting for clk. Force leds=0 in mode 1 -> next step gives 0x01.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Holds the pattern mode encoding and the fallback step period.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } led_mode_e;

    // Clocks per step used when the runtime period input is zero.
    localparam int unsigned DEFAULT_PERIOD = 50000000;

endpackage

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// Step pacing for the LED pattern sequencer.
// Ports: clk, rst_n (async low), run, step_req (pulse),
//        period (0 = DEFAULT_PERIOD) -> step (one-cycle strobe).
module step_prescaler #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step_req,
    input  logic [CNT_W-1:0] period,
    output logic             step
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] per_eff;
    logic             req_q;
    logic             hit;

    assign per_eff = (period == '0) ? DEF_P : period;

    // >= rather than == so a period lowered below the current
    // count fires at once instead of wrapping the counter.
    assign hit = (cnt_q >= (per_eff - ONE));

    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (run) begin
            if (hit) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            // Paused: counter holds, a registered request steps once.
            step = req_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            req_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            // Requests taken while running are dropped here.
            req_q <= step_req & ~run;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// N-bit LED pattern sequencer: rotate left/right, bounce, fill/drain.
// Ports: clk, rst_n, run, step_req, mode[1:0], period -> leds, tick, dir.
module led_pattern_sequencer #(
    parameter int unsigned N_LEDS         = 8,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = led_pkg::DEFAULT_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step_req,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  period,
    output logic [N_LEDS-1:0] leds,
    output logic              tick,
    output logic              dir
);

    import led_pkg::*;

    localparam logic [N_LEDS-1:0] LED0 = N_LEDS'(1);

    logic [N_LEDS-1:0] leds_q;
    logic [N_LEDS-1:0] leds_d;
    logic              dir_q;
    logic              dir_d;
    logic              tick_q;
    led_mode_e         mode_q;
    led_mode_e         mode_d;
    led_mode_e         mode_in;
    logic              step;

    step_prescaler #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_presc (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .step_req (step_req),
        .period   (period),
        .step     (step)
    );

    assign mode_in = led_mode_e'(mode);

    always_comb begin
        leds_d = leds_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (step) begin
            if (mode_in != mode_q) begin
                // Mode change: restart from LED0, no move this step.
                leds_d = LED0;
                dir_d  = 1'b0;
                mode_d = mode_in;
            end else if (leds_q == '0 && mode_q != MODE_FILL) begin
                // Blank bank is only legal in fill/drain; recover.
                leds_d = LED0;
                dir_d  = 1'b0;
            end else begin
                unique case (mode_q)
                    MODE_ROTL: begin
                        leds_d = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                    end
                    MODE_ROTR: begin
                        leds_d = {leds_q[0], leds_q[N_LEDS-1:1]};
                    end
                    MODE_BOUNCE: begin
                        if (!dir_q) begin
                            leds_d = {leds_q[N_LEDS-2:0], 1'b0};
                            if (leds_d[N_LEDS-1]) dir_d = 1'b1;
                        end else begin
                            leds_d = {1'b0, leds_q[N_LEDS-1:1]};
                            if (leds_d[0]) dir_d = 1'b0;
                        end
                    end
                    MODE_FILL: begin
                        if (!dir_q) begin
                            leds_d = {leds_q[N_LEDS-2:0], 1'b1};
                            if (&leds_d) dir_d = 1'b1;
                        end else begin
                            leds_d = {leds_q[N_LEDS-2:0], 1'b0};
                            if (leds_d == '0) dir_d = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q <= LED0;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            mode_q <= MODE_ROTL;
        end else begin
            leds_q <= leds_d;
            dir_q  <= dir_d;
            tick_q <= step;
            mode_q <= mode_d;
        end
    end

    assign leds = leds_q;
    assign tick = tick_q;
    assign dir  = dir_q;

endmodule
